// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives every input vector onto a small gate-under-test,
// holds each one for SETTLE cycles, samples the gate output at the end of the
// window and compares it with the TRUTH table, counting mismatches.
// Optional feature macro: FIRST_FAIL_CAPTURE_EN (records the first failing vector).
module gate_truth_checker #(
  parameter int unsigned          N_IN   = 2,
  parameter logic [2**N_IN-1:0]   TRUTH  = 4'b1000,
  parameter int unsigned          SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y_in,
  output logic [N_IN-1:0] a_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned     ERR_W    = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
  logic              fail_valid_q, fail_valid_d;
`endif

  // State, vector index, settle counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
`endif
    end
  end

  // Next-state: start a run, step through vectors, compare at end of each window
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
`endif
        end
      end

      APPLY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (y_in != TRUTH[idx_q]) begin
            err_d = err_q + ERR_W'(1);
`ifdef FIRST_FAIL_CAPTURE_EN
            if (!fail_valid_q) begin
              fail_vec_d   = idx_q;
              fail_valid_d = 1'b1;
            end
`endif
          end
          if (idx_q == LAST_VEC) begin
            // Last vector stays on a_out while results are held
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + N_IN'(1);
            cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_out     = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;
`else
  assign fail_vec   = '0;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Testbench for gate_truth_checker: a behavioural gate (lookup of gate_tt)
// sits on a_out/y_in; each run is checked cycle by cycle against the
// expected vector schedule and finally against mismatch counts computed
// directly from the two truth tables.
module tb_gate_truth_checker;

  localparam int unsigned N_IN   = 2;
  localparam int unsigned NV     = 4;
  localparam int unsigned SETTLE = 2;
  localparam logic [3:0]  TRUTH  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       y_in;
  logic [1:0] a_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic       fail_valid;

  logic [3:0] gate_tt;

  int n_checks = 0;
  int n_errors = 0;

  gate_truth_checker #(
    .N_IN   (N_IN),
    .TRUTH  (TRUTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y_in       (y_in),
    .a_out      (a_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

  always #5 clk = ~clk;

  // Gate under test: arbitrary truth table chosen by the bench
  assign y_in = gate_tt[a_out];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int count_errs(input logic [3:0] tt);
    int n = 0;
    for (int i = 0; i < NV; i++) if (tt[i] != TRUTH[i]) n++;
    return n;
  endfunction

  function automatic int first_fail(input logic [3:0] tt);
    for (int i = 0; i < NV; i++) if (tt[i] != TRUTH[i]) return i;
    return -1;
  endfunction

  task automatic check_idle_zero(input string name);
    check({name, " a_out"},      32'(a_out),      0);
    check({name, " busy"},       32'(busy),       0);
    check({name, " done"},       32'(done),       0);
    check({name, " pass"},       32'(pass),       0);
    check({name, " err_count"},  32'(err_count),  0);
    check({name, " fail_vec"},   32'(fail_vec),   0);
    check({name, " fail_valid"}, 32'(fail_valid), 0);
  endtask

  // One complete run; called at a negedge, returns at a negedge
  task automatic run(input logic [3:0] tt, input bit repulse, input string name);
    int exp_err;
    int ff;
    int exp_fv;
    int exp_fvalid;
    gate_tt = tt;
    start   = 1'b1;
    @(posedge clk);            // E0
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NV * SETTLE; k++) begin
      check($sformatf("%s a_out@E0+%0d", name, k), 32'(a_out), 32'(k / SETTLE));
      check($sformatf("%s busy@E0+%0d", name, k),  32'(busy),  1);
      check($sformatf("%s done@E0+%0d", name, k),  32'(done),  0);
      if (k == 0) begin
        check({name, " cleared err"},   32'(err_count),  0);
        check({name, " cleared pass"},  32'(pass),       0);
        check({name, " cleared fvld"},  32'(fail_valid), 0);
      end
      start = (repulse && k == 3);
      @(negedge clk);
    end
    start = 1'b0;

    exp_err = count_errs(tt);
    ff      = first_fail(tt);
`ifdef FIRST_FAIL_CAPTURE_EN
    exp_fv     = (ff >= 0) ? ff : 0;
    exp_fvalid = (ff >= 0) ? 1 : 0;
`else
    exp_fv     = 0;
    exp_fvalid = 0;
`endif
    check({name, " done"},       32'(done),       1);
    check({name, " busy end"},   32'(busy),       0);
    check({name, " a_out end"},  32'(a_out),      NV - 1);
    check({name, " err_count"},  32'(err_count),  32'(exp_err));
    check({name, " pass"},       32'(pass),       (exp_err == 0) ? 1 : 0);
    check({name, " fail_vec"},   32'(fail_vec),   32'(exp_fv));
    check({name, " fail_valid"}, 32'(fail_valid), 32'(exp_fvalid));

    // Results hold while start stays low
    repeat (2) @(negedge clk);
    check({name, " done hold"}, 32'(done),      1);
    check({name, " err hold"},  32'(err_count), 32'(exp_err));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    gate_tt = TRUTH;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("idle");

    run(TRUTH,   1'b0, "good_and");
    run(4'b0000, 1'b0, "stuck0");
    run(4'b1111, 1'b0, "stuck1");
    run(TRUTH,   1'b1, "repulse");

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    @(posedge clk);            // E0
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk); // E0+3
    #2 rst = 1'b1;
    #1 check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_rst");
    run(TRUTH, 1'b0, "post_rst");

    // Randomised gates, restart timing and re-pulses
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(4'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
